// File: rtl/graph_mem_arbiter_pkg.sv
// Shared types and the round-robin pick used by the graph BRAM read-port arbiter.
package graph_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int MAX_REQ    = 8;
  localparam int IDX_W      = 3;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set bit of pending, scanning upward from ptr+1 and wrapping at num_req.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] pending,
                                    input logic [IDX_W-1:0]   ptr,
                                    input int                 num_req);
    pick_t p;
    int    j;
    p = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      j = (int'(ptr) + k) % num_req;
      if (k <= num_req && !p.found && pending[j[IDX_W-1:0]]) begin
        p.found = 1'b1;
        p.idx   = j[IDX_W-1:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/graph_mem_arbiter_if.sv
// Requester-side and BRAM-side signals of the graph memory read arbiter.
interface graph_mem_arbiter_if import graph_pkg::*; #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
);
  logic [NUM_REQ-1:0]        req_valid_in;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_in;
  logic [NUM_REQ-1:0]        resp_valid_out;
  logic [NUM_REQ*DATA_W-1:0] resp_data_out;
  logic                      bram_en_out;
  logic [ADDR_W-1:0]         bram_addr_out;
  logic [DATA_W-1:0]         bram_rdata_in;

  modport slave (
    input  req_valid_in, req_addr_in, bram_rdata_in,
    output resp_valid_out, resp_data_out, bram_en_out, bram_addr_out
  );

  modport master (
    output req_valid_in, req_addr_in, bram_rdata_in,
    input  resp_valid_out, resp_data_out, bram_en_out, bram_addr_out
  );
endinterface

// File: rtl/graph_mem_arbiter_rr_arbiter.sv
// Combinational round-robin pick; the pointer register lives in the parent.
module rr_arbiter import graph_pkg::*; #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);
  pick_t pick;

  always_comb begin
    pick  = rr_pick(MAX_REQ'(pending), ptr, NUM_REQ);
    found = pick.found;
    idx   = pick.idx;
  end
endmodule

// File: rtl/graph_mem_arbiter.sv
// Shares one graph BRAM read port among NUM_REQ fire-and-forget requesters,
// returning each read as a one-cycle pulse on the originating response port.
module graph_mem_arbiter import graph_pkg::*; #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LATENCY = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  graph_mem_arbiter_if.slave  bus,
  output logic                busy_out,
  output logic                overflow_out
);
  localparam int STAGES = LATENCY + 1;

  logic [NUM_REQ-1:0] pend;
  logic [ADDR_W-1:0]  slot_addr [NUM_REQ];
  logic [IDX_W-1:0]   rr_ptr;
  tag_t               tag_p [STAGES];

  logic               gnt_found;
  logic [IDX_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic [ADDR_W-1:0]  gnt_addr;
  logic [NUM_REQ-1:0] fin_onehot;
  logic               pipe_busy;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .pending (pend),
    .ptr     (rr_ptr),
    .found   (gnt_found),
    .idx     (gnt_idx)
  );

  always_comb begin
    gnt_onehot = '0;
    gnt_addr   = '0;
    fin_onehot = '0;
    pipe_busy  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_found && gnt_idx == IDX_W'(i)) begin
        gnt_onehot[i] = 1'b1;
        gnt_addr      = slot_addr[i];
      end
      if (tag_p[LATENCY].valid && tag_p[LATENCY].idx == IDX_W'(i))
        fin_onehot[i] = 1'b1;
    end
    for (int s = 0; s < STAGES; s++)
      pipe_busy = pipe_busy | tag_p[s].valid;
  end

  // Holding slots: a pulse on a slot still pending and not granted this edge is dropped.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pend         <= '0;
      overflow_out <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_valid_in[i]) begin
          if (pend[i] && !gnt_onehot[i]) overflow_out <= 1'b1;
          else                           pend[i]      <= 1'b1;
        end else if (gnt_onehot[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    for (int i = 0; i < NUM_REQ; i++)
      if (bus.req_valid_in[i] && (!pend[i] || gnt_onehot[i]))
        slot_addr[i] <= bus.req_addr_in[i*ADDR_W +: ADDR_W];
  end

  // Grant stage: drives the BRAM address and seeds the tag pipeline.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bus.bram_en_out   <= 1'b0;
      bus.bram_addr_out <= '0;
      rr_ptr            <= IDX_W'(NUM_REQ - 1);
      for (int s = 0; s < STAGES; s++) tag_p[s] <= '0;
    end else begin
      bus.bram_en_out <= gnt_found;
      if (gnt_found) begin
        bus.bram_addr_out <= gnt_addr;
        rr_ptr            <= gnt_idx;
      end
      tag_p[0] <= '{valid: gnt_found, idx: gnt_idx};
      for (int s = 1; s < STAGES; s++) tag_p[s] <= tag_p[s-1];
    end
  end

  // Response stage: BRAM data lands on the slice named by the final tag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bus.resp_valid_out <= '0;
      bus.resp_data_out  <= '0;
      busy_out           <= 1'b0;
    end else begin
      bus.resp_valid_out <= fin_onehot;
      for (int i = 0; i < NUM_REQ; i++)
        if (fin_onehot[i]) bus.resp_data_out[i*DATA_W +: DATA_W] <= bus.bram_rdata_in;
      busy_out <= (|pend) | bus.bram_en_out | pipe_busy;
    end
  end

endmodule

// File: tb/tb_graph_mem_arbiter.sv
// Bench for graph_mem_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_graph_mem_arbiter;
  localparam int NR   = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int LAT2 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  graph_mem_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();
  graph_mem_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus2 ();
  logic busy, ovf, busy2, ovf2;

  graph_mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)) dut (
    .clk_in(clk), .rst_in(rst), .bus(bus), .busy_out(busy), .overflow_out(ovf));
  graph_mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT2)) dut2 (
    .clk_in(clk), .rst_in(rst), .bus(bus2), .busy_out(busy2), .overflow_out(ovf2));

  // BRAM models: data = address, LATENCY edges after the BRAM samples the address.
  logic [AW-1:0] bp1 [LAT];
  logic [AW-1:0] bp2 [LAT2];
  always @(posedge clk) begin
    bp1[0] <= bus.bram_addr_out;
    for (int i = 1; i < LAT; i++) bp1[i] <= bp1[i-1];
    bp2[0] <= bus2.bram_addr_out;
    for (int i = 1; i < LAT2; i++) bp2[i] <= bp2[i-1];
  end
  assign bus.bram_rdata_in  = bp1[LAT-1];
  assign bus2.bram_rdata_in = bp2[LAT2-1];

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: slots, rr pointer, and a queue of reads due back at a given edge.
  typedef struct {int due; int idx; logic [AW-1:0] addr;} inflight_t;
  inflight_t     q[$];
  int            m_pend [NR];
  logic [AW-1:0] m_slot [NR];
  logic [DW-1:0] m_rdata [NR];
  int            m_rr;
  logic          m_ovf, m_en, m_busy;
  logic [AW-1:0] m_baddr;
  logic [NR-1:0] m_rv;
  int            cyc = 0;

  function automatic int model_pick();
    for (int k = 1; k <= NR; k++)
      if (m_pend[(m_rr + k) % NR] != 0) return (m_rr + k) % NR;
    return -1;
  endfunction

  function automatic logic [NR*DW-1:0] pack_rdata();
    logic [NR*DW-1:0] r;
    for (int i = 0; i < NR; i++) r[i*DW +: DW] = m_rdata[i];
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < NR; i++) begin m_pend[i] = 0; m_rdata[i] = '0; end
    m_rr = NR - 1; m_ovf = 0; m_en = 0; m_busy = 0; m_baddr = '0; m_rv = '0;
  endtask

  task automatic tick(input logic r, input logic [NR-1:0] v, input logic [NR*AW-1:0] a);
    int   g;
    int   oldp [NR];
    logic nbusy;
    rst = r;
    bus.req_valid_in = v;
    bus.req_addr_in  = a;
    @(posedge clk); #1;
    cyc++;
    if (r) model_reset();
    else begin
      nbusy = m_en || (q.size() > 0);
      for (int i = 0; i < NR; i++) if (m_pend[i] != 0) nbusy = 1'b1;
      g = model_pick();
      oldp = m_pend;
      m_en = (g >= 0);
      if (g >= 0) begin
        m_baddr = m_slot[g];
        m_pend[g] = 0;
        m_rr = g;
        q.push_back('{cyc + LAT + 1, g, m_slot[g]});
      end
      for (int i = 0; i < NR; i++)
        if (v[i]) begin
          if (oldp[i] != 0 && g != i) m_ovf = 1'b1;
          else begin m_pend[i] = 1; m_slot[i] = a[i*AW +: AW]; end
        end
      m_rv = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        m_rv[q[0].idx] = 1'b1;
        m_rdata[q[0].idx] = q[0].addr;
        void'(q.pop_front());
      end
      m_busy = nbusy;
    end
    chk("resp_valid", bus.resp_valid_out, m_rv);
    chk("resp_data", bus.resp_data_out, pack_rdata());
    chk("bram_en", bus.bram_en_out, m_en);
    if (m_en) chk("bram_addr", bus.bram_addr_out, m_baddr);
    chk("busy", busy, m_busy);
    chk("overflow", ovf, m_ovf);
  endtask

  initial begin
    logic [AW-1:0]    gq[$];
    logic [NR-1:0]    rq[$];
    logic [DW-1:0]    dq[$];
    logic [AW-1:0]    tmp, orig2;
    logic [NR-1:0]    vv;
    logic [NR*AW-1:0] aa;
    int               g, ng, nr;

    bus.req_valid_in = '0; bus.req_addr_in = '0;
    bus2.req_valid_in = '0; bus2.req_addr_in = '0;
    model_reset();

    // Reset state
    tick(1, '0, '0); tick(1, '0, '0);
    chk("rst_bram_addr", bus.bram_addr_out, 0);
    chk("rst_resp_data", bus.resp_data_out, 0);
    chk("rst_busy", busy, 0);

    // Single uncontended request: 4-cycle latency
    tick(0, '0, '0); tick(0, '0, '0);
    tick(0, 3'b001, {32'h0, 32'h0, 32'h10});
    tick(0, '0, '0);
    chk("t1_en", bus.bram_en_out, 1);
    chk("t1_addr", bus.bram_addr_out, 32'h10);
    tick(0, '0, '0); tick(0, '0, '0);
    chk("t1_no_early_resp", bus.resp_valid_out, 0);
    tick(0, '0, '0);
    chk("t1_resp_valid", bus.resp_valid_out, 3'b001);
    chk("t1_resp_data", bus.resp_data_out[31:0], 32'h10);
    tick(0, '0, '0);
    chk("t1_busy_low", busy, 0);

    // All three at once, fresh from reset
    tick(1, '0, '0);
    tick(0, 3'b111, {32'h300, 32'h200, 32'h100});
    for (int t = 0; t < 8; t++) begin
      tick(0, '0, '0);
      if (bus.bram_en_out) gq.push_back(bus.bram_addr_out);
      if (bus.resp_valid_out != 0) begin
        rq.push_back(bus.resp_valid_out);
        for (int i = 0; i < NR; i++)
          if (bus.resp_valid_out[i]) dq.push_back(bus.resp_data_out[i*DW +: DW]);
      end
    end
    chk("t2_ngrant", gq.size(), 3);
    chk("t2_nresp", rq.size(), 3);
    for (int i = 0; i < 3 && i < gq.size() && i < rq.size() && i < dq.size(); i++) begin
      chk("t2_grant_order", gq[i], 32'h100 * (i + 1));
      chk("t2_resp_order", rq[i], 3'b001 << i);
      chk("t2_resp_data", dq[i], 32'h100 * (i + 1));
    end

    // Requester 1 pulsing every cycle
    ng = 0; nr = 0;
    for (int t = 0; t < 16; t++) begin
      aa = '0; aa[AW +: AW] = 32'h1000 + t;
      tick(0, (t < 10) ? 3'b010 : 3'b000, aa);
      if (bus.bram_en_out) ng++;
      if (bus.resp_valid_out == 3'b010) nr++;
    end
    chk("t3_grants", ng, 10);
    chk("t3_resps", nr, 10);
    chk("t3_no_overflow", ovf, 0);

    // Requesters 0 and 2 kept pending: alternation, then an overflow on 2
    tick(1, '0, '0);
    tick(0, 3'b101, {32'hC00, 32'h0, 32'hA00});
    orig2 = 32'hC00;
    gq.delete();
    for (int k = 0; k < 6; k++) begin
      g = model_pick();
      vv = '0; aa = '0;
      if (g >= 0) begin
        vv[g] = 1'b1;
        aa[g*AW +: AW] = (g == 0) ? 32'hA01 + k : 32'hC01 + k;
        if (g == 2) orig2 = 32'hC01 + k;
      end
      tick(0, vv, aa);
      gq.push_back(bus.bram_addr_out);
    end
    for (int k = 0; k < 6 && k < gq.size(); k++) begin
      tmp = gq[k];
      chk("t4_alternate", tmp[11:8], (k % 2 == 0) ? 4'hA : 4'hC);
    end
    chk("t4_no_overflow_yet", ovf, 0);
    tick(0, 3'b100, {32'hBAD, 32'h0, 32'h0});
    chk("t4_overflow", ovf, 1);
    chk("t4_grant0", bus.bram_addr_out, 32'hA05);
    tick(0, '0, '0);
    chk("t4_orig2_served", bus.bram_addr_out, orig2);
    for (int t = 0; t < 6; t++) tick(0, '0, '0);
    chk("t4_overflow_sticky", ovf, 1);

    // Random traffic
    for (int t = 0; t < 300; t++) begin
      vv = NR'($urandom_range(0, 7) & $urandom_range(0, 7));
      aa = {$urandom(), $urandom(), $urandom()};
      tick(0, vv, aa);
    end
    for (int t = 0; t < 10; t++) tick(0, '0, '0);

    // Reset with a read in flight
    tick(1, '0, '0);
    tick(0, 3'b010, {32'h0, 32'h55, 32'h0});
    tick(0, '0, '0);
    chk("t5_granted", bus.bram_en_out, 1);
    tick(1, '0, '0);
    chk("t5_rst_en", bus.bram_en_out, 0);
    chk("t5_rst_addr", bus.bram_addr_out, 0);
    chk("t5_rst_ovf", ovf, 0);
    nr = 0;
    for (int t = 0; t < 6; t++) begin
      tick(0, '0, '0);
      if (bus.resp_valid_out != 0) nr++;
    end
    chk("t5_no_stale_resp", nr, 0);
    tick(0, 3'b001, {32'h0, 32'h0, 32'h77});
    tick(0, '0, '0); tick(0, '0, '0); tick(0, '0, '0);
    chk("t5_not_yet", bus.resp_valid_out, 0);
    tick(0, '0, '0);
    chk("t5_resp_valid", bus.resp_valid_out, 3'b001);
    chk("t5_resp_data", bus.resp_data_out[31:0], 32'h77);

    // LATENCY=4 instance: response after E+6
    bus2.req_valid_in = 3'b001; bus2.req_addr_in = {32'h0, 32'h0, 32'h66};
    tick(0, '0, '0);
    bus2.req_valid_in = '0;
    tick(0, '0, '0);
    chk("t6_en", bus2.bram_en_out, 1);
    chk("t6_addr", bus2.bram_addr_out, 32'h66);
    nr = 0;
    for (int t = 0; t < 4; t++) begin
      tick(0, '0, '0);
      if (bus2.resp_valid_out != 0) nr++;
    end
    chk("t6_no_early_resp", nr, 0);
    tick(0, '0, '0);
    chk("t6_resp_valid", bus2.resp_valid_out, 3'b001);
    chk("t6_resp_data", bus2.resp_data_out[31:0], 32'h66);
    tick(0, '0, '0);
    chk("t6_resp_pulse", bus2.resp_valid_out, 0);
    chk("t6_overflow", ovf2, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/graph_mem_arbiter.md
Name: graph_mem_arbiter

Overview:
- Shares one read port of the graph BRAM between NUM_REQ graph_fetch-style requesters (position port, neighbour port, or several fetch units).
- Requesters issue fire-and-forget single-cycle read pulses with no ready signal. The block holds them, grants one per cycle round-robin, tracks the BRAM latency with a tag pipeline, and returns the data as a one-cycle valid pulse on the originating requester's response port.
- Sits between the fetch units and graph memory.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 32, address width on requester and BRAM side.
- DATA_W, 32, BRAM word width.
- LATENCY, 2, BRAM read latency in cycles, from address-registered edge to data-sampled edge (>=1).

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  synchronous active-high reset.
- req_valid_in  in  NUM_REQ  per-requester read pulse.
- req_addr_in  in  NUM_REQ*ADDR_W  per-requester address; requester i occupies bits [i*ADDR_W +: ADDR_W].
- resp_valid_out  out  NUM_REQ  one-cycle response pulse per requester.
- resp_data_out  out  NUM_REQ*DATA_W  per-requester read data; meaningful only with its resp_valid_out bit.
- bram_en_out  out  1  BRAM read enable.
- bram_addr_out  out  ADDR_W  BRAM read address.
- bram_rdata_in  in  DATA_W  BRAM read data.
- busy_out  out  1  any request pending or in flight.
- overflow_out  out  1  sticky: a request was dropped.

Behaviour:
- One clock (clk_in); reset is synchronous and active-high (rst_in).
- Reset values: all pending bits 0, tag pipeline valid bits 0, rr pointer = NUM_REQ-1 (so requester 0 wins first), bram_en_out 0, bram_addr_out 0, resp_valid_out 0, resp_data_out 0, busy_out 0, overflow_out 0.
- Reset mid-operation: all in-flight reads are discarded and no response pulses occur after reset.
- Holding: each requester has a one-deep slot (pending bit + address). req_valid_in[i] sampled high at edge E loads slot i.
- Arbitration: each cycle, the pending slots are scanned starting at rr+1, wrapping modulo NUM_REQ. The first set slot g is granted at the next edge: bram_en_out<=1, bram_addr_out<=addr[g], pending[g]<=0, rr<=g. If no slot is pending, bram_en_out<=0 and rr is held.
- Throughput: at most one grant per cycle; full BRAM bandwidth under load.
- Tag pipeline: LATENCY+1 stages of {valid, index}. Stage 0 is loaded with {bram_en_out, g} on the grant edge. At the final stage, bram_rdata_in is registered into resp_data_out slice index and resp_valid_out[index] is pulsed. All other resp_valid_out bits are 0 that cycle; other data slices hold their values.
- Latency:
  - Uncontended: a request sampled at edge E has its address registered at E+1; resp_valid_out is high in the cycle after edge E+2+LATENCY.
  - Total with LATENCY=2: 4 cycles.
  - Responses to one requester are returned in issue order.
- Simultaneous events:
  - A new pulse on a slot at the same edge that slot is granted: the slot reloads with the new address, with no overflow.
  - A new pulse on a slot that is still pending and not granted that edge: the new request is dropped, the old one is kept, and overflow_out<=1 (sticky until reset).
  - A requester pulsing every cycle alone is granted every cycle, with no overflow.
- busy_out = OR(pending) | bram_en_out | OR(pipeline valid), registered.
- Fairness: with K requesters continuously pending, each is served at least once every K grants.
- Widths: no address arithmetic is performed; addresses pass through unchanged.

Decomposition:
- Package graph_pkg:
  - ADDR_W and DATA_W defaults.
  - Typedef tag_t {logic valid; logic [$clog2(NUM_REQ)-1:0] idx}.
  - Function rr_pick(pending, ptr) returning {found, idx}.
- Sub-module rr_arbiter (NUM_REQ): combinational round-robin pick from pending and rr pointer. The pointer register stays in the top.

Test Plan:
- Reset, then requester 0 pulses addr 0x10 at edge 5 -> bram_en_out=1, bram_addr_out=0x10 after edge 6; resp_valid_out=3'b001 with BRAM data 0x10 (bench model returns data=addr) after edge 9; busy_out low after edge 10.
- All three requesters pulse at the same edge (addrs 0x100, 0x200, 0x300) -> grants in order 0,1,2 on consecutive cycles; responses pulse 001, 010, 100 on consecutive cycles, each carrying its own address.
- Requester 1 pulses every cycle for 10 cycles, others idle -> 10 back-to-back grants, 10 responses in order, overflow_out stays 0.
- Requesters 0 and 2 both held pending continuously -> grants alternate 0,2,0,2; requester 2 pulses a new address while still pending -> overflow_out=1 and the original address is served.
- Reset asserted one cycle after a grant with data in flight -> no resp_valid_out pulse afterwards; all outputs at reset values; the next request is served normally with 4-cycle latency.
- LATENCY=4 build with a single request -> response after edge E+6.
